// File: rtl/cheb_pkg.sv
// Shared definitions for the Chebyshev term generator: FSM states, default
// parameters and the Q-format / index-width helpers used by every file.
package cheb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT0,
    ST_EMIT1,
    ST_RECUR
  } cheb_state_e;

  localparam int CHEB_WL_X_DEF   = 8;
  localparam int CHEB_DEGREE_DEF = 3;

  // Fraction bits of x (Q1.F) and of the terms (Q2.F) are the same F.
  function automatic int cheb_frac_bits(input int wl_x);
    return wl_x - 1;
  endfunction

  // ceil(ld(degree+1)): bits needed to count terms 0..degree.
  function automatic int cheb_widen(input int degree);
    return $clog2(degree + 1);
  endfunction

  localparam int CHEB_FRAC_DEF      = cheb_frac_bits(CHEB_WL_X_DEF);
  localparam int CHEB_ADD_WIDEN_DEF = cheb_widen(CHEB_DEGREE_DEF);

endpackage

// File: rtl/cheb_recur_alu.sv
// One step of the Chebyshev recurrence:
// T_{k+1} = sat(2*((x*T_k) >>> F) - T_{k-1}), purely combinational.
module cheb_recur_alu
  import cheb_pkg::*;
#(
  parameter int WL_X = CHEB_WL_X_DEF,
  parameter int WL_T = WL_X + 1
) (
  input  logic [WL_X-1:0] i_x,
  input  logic [WL_T-1:0] i_tk,
  input  logic [WL_T-1:0] i_tkm1,
  output logic [WL_T-1:0] o_tnext
);

  localparam int WL_I = WL_X + WL_T + 1;
  localparam int FRAC = cheb_frac_bits(WL_X);
  localparam logic signed [WL_I-1:0] SAT_MAX = WL_I'((2 ** (WL_T - 1)) - 1);
  localparam logic signed [WL_I-1:0] SAT_MIN = WL_I'(-(2 ** (WL_T - 1)));

  logic signed [WL_I-1:0] w_x;
  logic signed [WL_I-1:0] w_tk;
  logic signed [WL_I-1:0] w_tkm1;
  logic signed [WL_I-1:0] w_prod;
  logic signed [WL_I-1:0] w_shift;
  logic signed [WL_I-1:0] w_diff;

  // Widen before multiplying so the product and the doubled difference
  // can never wrap; the arithmetic shift rounds toward -inf.
  assign w_x     = WL_I'($signed(i_x));
  assign w_tk    = WL_I'($signed(i_tk));
  assign w_tkm1  = WL_I'($signed(i_tkm1));
  assign w_prod  = w_x * w_tk;
  assign w_shift = w_prod >>> FRAC;
  assign w_diff  = (w_shift <<< 1) - w_tkm1;

  // NOTE: o_tnext gets a default before the branches so no latch is inferred.
  always_comb begin
    o_tnext = w_diff[WL_T-1:0];
    if (w_diff > SAT_MAX) begin
      o_tnext = SAT_MAX[WL_T-1:0];
    end else if (w_diff < SAT_MIN) begin
      o_tnext = SAT_MIN[WL_T-1:0];
    end
  end

endmodule

// File: rtl/cheb_term_gen.sv
// Streams Chebyshev terms T_0(x)..T_DEGREE(x) one per accepted handshake,
// with all outputs registered and held stable under backpressure.
module cheb_term_gen
  import cheb_pkg::*;
#(
  parameter int WL_X   = CHEB_WL_X_DEF,
  parameter int DEGREE = CHEB_DEGREE_DEF,
  localparam int WL_T  = WL_X + 1,
  localparam int WL_K  = cheb_widen(DEGREE)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [WL_X-1:0] x,
  output logic            busy,
  output logic            t_valid,
  input  logic            t_ready,
  output logic [WL_T-1:0] t_data,
  output logic [WL_K-1:0] t_index,
  output logic            t_last
);

  localparam logic [WL_K-1:0] LAST_IDX = WL_K'(DEGREE);
  localparam logic [WL_T-1:0] T_ONE    = WL_T'(1) << cheb_frac_bits(WL_X);

  cheb_state_e     r_state;
  logic [WL_X-1:0] r_x;
  logic [WL_T-1:0] r_tk;
  logic [WL_T-1:0] r_tkm1;
  logic [WL_K-1:0] r_index;
  logic            r_valid;
  logic            r_busy;
  logic            r_last;

  logic [WL_T-1:0] w_tnext;
  logic [WL_K-1:0] w_index_next;
  logic            w_xfer;

  assign w_xfer       = r_valid && t_ready;
  assign w_index_next = r_index + WL_K'(1);

  cheb_recur_alu #(
    .WL_X(WL_X),
    .WL_T(WL_T)
  ) u_alu (
    .i_x    (r_x),
    .i_tk   (r_tk),
    .i_tkm1 (r_tkm1),
    .o_tnext(w_tnext)
  );

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchronous reset clears every datapath register, not just the state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_tk    <= '0;
      r_tkm1  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x     <= x;
            r_tk    <= T_ONE;
            r_tkm1  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_EMIT0;
          end
        end
        ST_EMIT0: begin
          if (w_xfer) begin
            r_tkm1  <= r_tk;
            r_tk    <= {r_x[WL_X-1], r_x};
            r_index <= w_index_next;
            r_last  <= (w_index_next == LAST_IDX);
            r_state <= ST_EMIT1;
          end
        end
        ST_EMIT1, ST_RECUR: begin
          if (w_xfer) begin
            if (r_last) begin
              r_tk    <= '0;
              r_tkm1  <= '0;
              r_index <= '0;
              r_last  <= 1'b0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tkm1  <= r_tk;
              r_tk    <= w_tnext;
              r_index <= w_index_next;
              r_last  <= (w_index_next == LAST_IDX);
              r_state <= ST_RECUR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign t_valid = r_valid;
  assign t_data  = r_tk;
  assign t_index = r_index;
  assign t_last  = r_last;

endmodule

// File: tb/tb_cheb_term_gen.sv
// Scoreboard bench for cheb_term_gen: DEGREE=3 and DEGREE=1 instances,
// hand-computed term sequences queued at start, popped by per-DUT monitors.
module tb_cheb_term_gen;

  typedef struct {
    int data;
    int idx;
    int last;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn;
  logic       start3, start1;
  logic [7:0] x3, x1;
  logic       t_ready3, t_ready1;

  logic       busy3, t_valid3, t_last3;
  logic [8:0] t_data3;
  logic [1:0] t_index3;
  logic       busy1, t_valid1, t_last1;
  logic [8:0] t_data1;
  logic [0:0] t_index1;

  exp_t q3[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  cheb_term_gen #(.WL_X(8), .DEGREE(3)) dut3 (
    .clock(clock), .resetn(resetn), .start(start3), .x(x3), .busy(busy3),
    .t_valid(t_valid3), .t_ready(t_ready3), .t_data(t_data3),
    .t_index(t_index3), .t_last(t_last3)
  );

  cheb_term_gen #(.WL_X(8), .DEGREE(1)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .x(x1), .busy(busy1),
    .t_valid(t_valid1), .t_ready(t_ready1), .t_data(t_data1),
    .t_index(t_index1), .t_last(t_last1)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitors: a term is consumed on the edge following a negedge where
  // valid && ready is seen with reset released.
  always @(negedge clock) begin
    if (resetn && t_valid3 && t_ready3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d3_unexpected_term actual=%0d expected=none", $signed(t_data3));
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("d3_data", $signed(t_data3), e.data);
        check("d3_index", t_index3, e.idx);
        check("d3_last", t_last3, e.last);
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && t_valid1 && t_ready1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_term actual=%0d expected=none", $signed(t_data1));
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_data", $signed(t_data1), e.data);
        check("d1_index", t_index1, e.idx);
        check("d1_last", t_last1, e.last);
      end
    end
  end

  task automatic push3(input int d0, input int d1, input int d2, input int d3);
    q3.push_back('{d0, 0, 0});
    q3.push_back('{d1, 1, 0});
    q3.push_back('{d2, 2, 0});
    q3.push_back('{d3, 3, 1});
  endtask

  task automatic pulse_start3(input logic [7:0] xv);
    start3 = 1'b1;
    x3     = xv;
    @(posedge clock);
    #1;
    start3 = 1'b0;
  endtask

  task automatic wait_idle3(input string name);
    int n = 0;
    while ((q3.size() != 0 || busy3) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check({name, "_queue_drained"}, q3.size(), 0);
    check({name, "_busy_low"}, busy3, 0);
  endtask

  task automatic run3(input string name, input logic [7:0] xv,
                      input int d0, input int d1, input int d2, input int d3);
    push3(d0, d1, d2, d3);
    pulse_start3(xv);
    wait_idle3(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    start3 = 1'b0; start1 = 1'b0;
    x3 = '0; x1 = '0;
    t_ready3 = 1'b1; t_ready1 = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("reset_busy3", busy3, 0);
    check("reset_valid3", t_valid3, 0);
    check("reset_data3", t_data3, 0);
    check("reset_index3", t_index3, 0);
    check("reset_last3", t_last3, 0);
    check("reset_valid1", t_valid1, 0);

    // x=0.5: one term per cycle, then idle the cycle after the last.
    push3(128, 64, -64, -128);
    pulse_start3(8'd64);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("x64_valid_each_cycle", t_valid3, 1);
      check("x64_busy_each_cycle", busy3, 1);
    end
    @(negedge clock);
    check("x64_busy_after_last", busy3, 0);
    check("x64_valid_after_last", t_valid3, 0);
    check("x64_idle_data", t_data3, 0);
    check("x64_idle_index", t_index3, 0);
    check("x64_idle_last", t_last3, 0);
    check("x64_queue_empty", q3.size(), 0);

    // Start in the cycle right after the last transfer.
    run3("xm128", 8'h80, 128, -128, 128, -128);
    run3("xm64", 8'hC0, 128, -64, -64, 128);
    run3("x127", 8'd127, 128, 127, 124, 119);
    run3("xm127", 8'h81, 128, -127, 124, -121);

    // Backpressure on the first term.
    t_ready3 = 1'b0;
    push3(128, 64, -64, -128);
    pulse_start3(8'd64);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_valid", t_valid3, 1);
      check("stall_data", $signed(t_data3), 128);
      check("stall_index", t_index3, 0);
      check("stall_last", t_last3, 0);
    end
    t_ready3 = 1'b1;
    wait_idle3("stall");

    // A second start while busy must be ignored.
    push3(128, 64, -64, -128);
    pulse_start3(8'd64);
    pulse_start3(8'd32);
    wait_idle3("restart_ignored");

    // Reset right after the T1 transfer.
    q3.push_back('{128, 0, 0});
    q3.push_back('{64, 1, 0});
    pulse_start3(8'd64);
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("midreset_queue", q3.size(), 0);
    check("midreset_valid", t_valid3, 0);
    check("midreset_busy", busy3, 0);
    check("midreset_data", t_data3, 0);
    check("midreset_index", t_index3, 0);
    @(posedge clock);
    #1;
    run3("x0_after_reset", 8'd0, 128, 0, -128, 0);

    // DEGREE=1: two terms, last on the second, idle right after.
    q1.push_back('{128, 0, 0});
    q1.push_back('{100, 1, 1});
    start1 = 1'b1;
    x1     = 8'd100;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    @(negedge clock);
    check("d1_valid_t0", t_valid1, 1);
    @(negedge clock);
    check("d1_valid_t1", t_valid1, 1);
    @(negedge clock);
    check("d1_busy_after_last", busy1, 0);
    check("d1_valid_after_last", t_valid1, 0);
    check("d1_queue_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cheb_term_gen.md
CHEB_TERM_GEN -- requirements
Module: cheb_term_gen

Interface
REQ-001 The block SHALL have parameter WL_X, default 8: word length of x, signed Q1.(WL_X-1).
REQ-002 The block SHALL have parameter DEGREE, default 3: highest Chebyshev index emitted, legal range 1..15.
REQ-003 Derived widths SHALL be WL_T = WL_X+1 (signed Q2.(WL_X-1)) and WL_K = clog2(DEGREE+1).
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: resetn  input  1  synchronous, active-low reset.
REQ-006 Port: start  input  1  request to evaluate terms for x.
REQ-007 Port: x  input  WL_X  evaluation point, sampled when start is accepted.
REQ-008 Port: busy  output  1  high from start acceptance until the last term handshakes.
REQ-009 Port: t_valid  output  1  t_data, t_index and t_last are valid.
REQ-010 Port: t_ready  input  1  downstream (coefficient multiplier / adder tree) accepts the term.
REQ-011 Port: t_data  output  WL_T  T_k(x), Q2.(WL_X-1).
REQ-012 Port: t_index  output  WL_K  k of the current term.
REQ-013 Port: t_last  output  1  high when t_index == DEGREE.

Function
REQ-014 The FSM SHALL have states IDLE, EMIT0, EMIT1 and RECUR.
REQ-015 start SHALL be accepted only in IDLE; x is registered and the state moves to EMIT0 at the same edge.
REQ-016 start in any non-IDLE state SHALL be ignored, with no change to x or the sequence.
REQ-017 EMIT0 SHALL drive t_valid=1, t_data=2^(WL_X-1) (+1.0) and t_index=0, one cycle after acceptance.
REQ-018 EMIT1 SHALL drive t_data = sign-extended latched x and t_index=1.
REQ-019 RECUR SHALL drive t_data = T_k, computed as T_{k+1} = sat(2*((x*T_k) >>> (WL_X-1)) - T_{k-1}).
REQ-020 In the RECUR computation, the shift SHALL be arithmetic (truncation toward -inf), intermediates SHALL be at least WL_X+WL_T+1 bits, and sat SHALL clamp to [-2^(WL_T-1), 2^(WL_T-1)-1].
REQ-021 A transfer SHALL occur only on an edge where t_valid && t_ready.
REQ-022 On a transfer, the next term SHALL be registered at that same edge, giving one term per cycle with t_ready held high.
REQ-023 While t_valid && !t_ready, t_data, t_index and t_last SHALL remain stable.
REQ-024 A transfer with t_last=1 SHALL return the FSM to IDLE; t_valid and busy go low on the following cycle.
REQ-025 When DEGREE=1, the EMIT1 term SHALL carry t_last=1 and RECUR SHALL never be entered.
REQ-026 In IDLE, t_valid=0, busy=0, t_last=0, and t_data/t_index SHALL hold 0.
REQ-027 A start asserted in the cycle after the last transfer (IDLE) SHALL be accepted normally.

Reset
REQ-028 resetn=0 at any rising edge, including mid-sequence or during a stall, SHALL force IDLE.
REQ-029 That reset SHALL clear x, T_k, T_{k-1} and the index registers to 0.
REQ-030 After reset, all outputs SHALL read 0 from the next cycle; no partial sequence resumes.

Structure
REQ-031 A shared package cheb_pkg SHALL hold the FSM state enum, the DEGREE default and Q-format fraction-bit constants; the adder widening constant (ceil(ld(DEGREE+1))) SHALL be the same package value.
REQ-032 One sub-module, cheb_recur_alu (combinational multiply, shift, double, subtract, saturate), SHALL be instantiated once.

Verification
REQ-033 WL_X=8, DEGREE=3, x=64, start pulse, t_ready=1 -> t_data 128, 64, -64, -128 on consecutive cycles, t_index 0..3, t_last only on -128.
REQ-034 x=-128 (-1.0), t_ready=1 -> 128, -128, 128, -128.
REQ-035 x=64, t_ready=0 for 3 cycles after first t_valid -> t_data=128, t_index=0 held stable; sequence then completes unchanged.
REQ-036 start re-pulsed with x=32 while busy -> ignored; terms remain those of x=64.
REQ-037 resetn=0 after the T1 transfer -> next cycle t_valid=0, busy=0, t_data=0; a new start with x=0 yields 128, 0, -128, 0.
REQ-038 DEGREE=1, x=100 -> two terms 128, 100; t_last on the second; busy low the cycle after.
